// File: rtl/riscv_instr_encoder.sv
// riscv_instr_encoder
//   Encodes a set of RV32I instruction fields into a 32-bit instruction word.
//   The encoded word sits in a one-entry output register, and both sides use
//   a valid/ready handshake.
//
//   Handshake contract (same on both sides): a transfer happens on a rising
//   clk edge where valid && ready are both high. A producer holding valid
//   keeps its payload stable until that edge. ready may depend on the
//   partner's ready, but it never depends on valid.
//
//   Ports
//     clk, rst          clock; asynchronous active-low reset
//     in_valid/in_ready input handshake for the field set
//     opcode, func3, func7, rd, rs1, rs2, imm   instruction fields
//     out_valid/out_ready output handshake for the encoded word
//     instr, err        encoded word and its sideband error flag
//     instr_count       16-bit wrapping count of output handshakes
//     state_dbg         FSM state for checkers (0 = EMPTY, 1 = FULL)
//
//   Configuration
//     RISCV_ENC_RANGE_CHECK_EN  When defined, err is also raised if imm does
//                               not fit its format. The word is still emitted
//                               with truncated fields.
module riscv_instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [15:0] instr_count,
  output logic        state_dbg
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] enc_word;
  logic        bad_opcode;
  logic        range_err;
  logic        fire;

  // The encoder runs purely on the current inputs. The result is only
  // captured on an input handshake.
  always_comb begin
    enc_word   = 32'h0000_0000;
    bad_opcode = 1'b0;
    case (opcode)
      OP_R:
        enc_word = {func7, rs2, rs1, func3, rd, opcode};
      OP_IMM, OP_LOAD, OP_JALR:
        enc_word = {imm[11:0], rs1, func3, rd, opcode};
      OP_STORE:
        enc_word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      OP_BRANCH:
        enc_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      OP_LUI:
        enc_word = {imm[31:12], rd, opcode};
      OP_JAL:
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default:
        bad_opcode = 1'b1;
    endcase
  end

`ifdef RISCV_ENC_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic               fit_12;
  logic               fit_b;
  logic               fit_j;

  assign simm   = $signed(imm);
  assign fit_12 = (simm >= -32'sd2048) && (simm <= 32'sd2047);
  // B and J offsets are byte offsets to 2-byte-aligned targets, so an odd
  // value cannot be represented.
  assign fit_b  = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
  assign fit_j  = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];

  always_comb begin
    range_err = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_STORE: range_err = !fit_12;
      OP_BRANCH:                          range_err = !fit_b;
      OP_JAL:                             range_err = !fit_j;
      OP_LUI:                             range_err = (imm[11:0] != 12'h000);
      default:                            range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  // A FULL register can still accept a word on the edge where the consumer
  // drains the current one. This keeps the throughput at one word per cycle.
  assign in_ready  = (state == EMPTY) || out_ready;
  assign fire      = in_valid && in_ready;
  assign out_valid = (state == FULL);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= EMPTY;
      instr       <= 32'h0000_0000;
      err         <= 1'b0;
      instr_count <= 16'h0000;
    end else begin
      if (out_valid && out_ready) begin
        instr_count <= instr_count + 16'd1;
      end
      case (state)
        EMPTY: begin
          if (fire) begin
            state <= FULL;
            instr <= enc_word;
            err   <= bad_opcode | range_err;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (in_valid) begin
              instr <= enc_word;
              err   <= bad_opcode | range_err;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
module tb_riscv_instr_encoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  opcode = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic        err;
  logic [15:0] instr_count;
  logic        state_dbg;

  riscv_instr_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .func7(func7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err(err), .instr_count(instr_count),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];        // {err, instr} of words still owed by the DUT
  logic [15:0] exp_count = '0;
  int n_vec = 0;
  int n_err = 0;

  // Reference encoder. It assembles the word field by field from the ISA
  // layout and does the range check with plain integer arithmetic.
  function automatic logic [32:0] ref_encode(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [31:0] im);
    longint v;
    logic [31:0] w;
    bit e;
    v = longint'($signed(im));
    w = 32'h0;
    e = 1'b0;
    case (op)
      7'b0110011: w = {f7, s2, s1, f3, d, op};
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w = {im[11:0], s1, f3, d, op};
        e = (v < -2048) || (v > 2047);
      end
      7'b0100011: begin
        w = {im[11:5], s2, s1, f3, im[4:0], op};
        e = (v < -2048) || (v > 2047);
      end
      7'b1100011: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      7'b0110111: begin
        w = {im[31:12], d, op};
        e = (im % 4096) != 0;
      end
      7'b1101111: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
        e = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      end
      default: return {1'b1, 32'h0};
    endcase
`ifndef RISCV_ENC_RANGE_CHECK_EN
    e = 1'b0;
`endif
    return {e, w};
  endfunction

  // One clock cycle. First check the outputs against the model (inputs were
  // set beforehand), then advance the model across the edge.
  task automatic tick();
    logic exp_ready;
    logic exp_valid;
    logic do_fire;
    logic do_hs;
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_ready = !exp_valid || out_ready;
    n_vec++;
    if (in_ready !== exp_ready) begin
      n_err++;
      $display("FAIL in_ready: got %b want %b @%0t", in_ready, exp_ready, $time);
    end
    n_vec++;
    if (out_valid !== exp_valid) begin
      n_err++;
      $display("FAIL out_valid: got %b want %b @%0t", out_valid, exp_valid, $time);
    end
    if (exp_valid) begin
      n_vec++;
      if (instr !== exp_q[0][31:0]) begin
        n_err++;
        $display("FAIL instr: got %h want %h @%0t", instr, exp_q[0][31:0], $time);
      end
      n_vec++;
      if (err !== exp_q[0][32]) begin
        n_err++;
        $display("FAIL err: got %b want %b @%0t", err, exp_q[0][32], $time);
      end
    end
    n_vec++;
    if (instr_count !== exp_count) begin
      n_err++;
      $display("FAIL instr_count: got %0d want %0d @%0t", instr_count, exp_count, $time);
    end
    do_fire = in_valid && exp_ready;
    do_hs   = exp_valid && out_ready;
    @(posedge clk);
    if (do_hs) begin
      void'(exp_q.pop_front());
      exp_count = exp_count + 16'd1;
    end
    if (do_fire) exp_q.push_back(ref_encode(opcode, func3, func7, rd, rs1, rs2, imm));
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [31:0] im);
    opcode = op; func3 = f3; func7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic drive_random();
    logic [6:0] ops[9];
    logic [31:0] edges[12];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b1101111, 7'b0000000};
    edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095,
              -32'sd4096, -32'sd4098, 32'd1048574, 32'd1048576, -32'sd1048576, 32'h0001_2000};
    opcode = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 7)];
    func3 = 3'($urandom); func7 = 7'($urandom);
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    case ($urandom_range(0, 2))
      0: imm = $urandom;
      1: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
      default: imm = edges[$urandom_range(0, 11)];
    endcase
  endtask

  // Send one field set with out_ready=1, then compare the registered word
  // against a literal.
  task automatic send_known(input string name, input logic [31:0] want_instr,
                            input logic want_err);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || instr !== want_instr || err !== want_err) begin
      n_err++;
      $display("FAIL %s: got v=%b instr=%h err=%b want v=1 instr=%h err=%b",
               name, out_valid, instr, err, want_instr, want_err);
    end
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || instr !== 32'h0 || err !== 1'b0 || instr_count !== 16'h0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b instr=%h err=%b cnt=%0d want 0/0/0/0",
               out_valid, instr, err, instr_count);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tick();
  endtask

  task automatic test_known_vectors();
    logic e2048;
`ifdef RISCV_ENC_RANGE_CHECK_EN
    e2048 = 1'b1;
`else
    e2048 = 1'b0;
`endif
    drive(7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    send_known("add_x3_x1_x2", 32'h002081B3, 1'b0);
    drive(7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF);
    send_known("addi_m1", 32'hFFF00293, 1'b0);
    drive(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    send_known("sw_8", 32'h0020A423, 1'b0);
    drive(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4);
    send_known("beq_m4", 32'hFE000EE3, 1'b0);
    drive(7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd2048);
    send_known("addi_2048", 32'h80000293, e2048);
    drive(7'b1111111, 3'd7, 7'd127, 5'd31, 5'd31, 5'd31, 32'hDEAD_BEEF);
    send_known("bad_opcode", 32'h0, 1'b1);
  endtask

  task automatic test_stall_back_to_back();
    logic [15:0] cnt0;
    drive_random(); in_valid = 1'b1; out_ready = 1'b0;
    tick();                                // EMPTY accepts although out_ready=0
    for (int i = 0; i < 5; i++) begin
      drive_random();                      // ignored while FULL and stalled
      tick();
    end
    cnt0 = exp_count;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_random();
      tick();
    end
    n_vec++;
    if (instr_count !== cnt0 + 16'd6) begin
      n_err++;
      $display("FAIL back_to_back_count: got %0d want %0d", instr_count, cnt0 + 16'd6);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_random();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset_while_full();
    drive_random(); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();                               // model confirms FULL here
    #2;
    rst = 1'b0;                           // mid-cycle, no clock edge involved
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || instr !== 32'h0 || err !== 1'b0 ||
        instr_count !== 16'h0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_while_full: got v=%b instr=%h err=%b cnt=%0d rdy=%b want 0/0/0/0/1",
               out_valid, instr, err, instr_count, in_ready);
    end
    exp_q.delete();
    exp_count = 16'h0;
    out_ready = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tick();
    drive_random(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_known_vectors();
    test_stall_back_to_back();
    test_random();
    test_reset_while_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/riscv_instr_encoder.md
RISCV_INSTR_ENCODER -- requirements
Module: riscv_instr_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 in_valid  input  1  field set on inputs is valid.
REQ-004 in_ready  output  1  encoder accepts a field set this cycle.
REQ-005 opcode  input  7  base opcode selecting format.
REQ-006 func3  input  3  funct3 field.
REQ-007 func7  input  7  funct7 field (R-type only).
REQ-008 rd, rs1, rs2  input  5 each  register indices.
REQ-009 imm  input  32  signed immediate, byte offset for B/J, full value for U (low 12 bits expected zero).
REQ-010 out_valid  output  1  instr holds an encoded word.
REQ-011 out_ready  input  1  consumer takes instr this cycle.
REQ-012 instr  output  32  encoded RV32I instruction word.
REQ-013 err  output  1  sideband with instr: unsupported opcode or immediate out of range.
REQ-014 instr_count  output  16  number of words handed off (out_valid && out_ready).

Function
REQ-015 Format from opcode: 0110011 R; 0010011, 0000011, 1100111 I; 0100011 S; 1100011 B; 0110111 U; 1101111 J.
REQ-016 R: {func7,rs2,rs1,func3,rd,opcode}; I: {imm[11:0],rs1,func3,rd,opcode}; S: {imm[11:5],rs2,rs1,func3,imm[4:0],opcode}.
REQ-017 B: {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],opcode}; U: {imm[31:12],rd,opcode}; J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-018 Unsupported opcode: instr=32'h00000000, err=1.
REQ-019 One-entry output register; FSM states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-020 in_ready = (state==EMPTY) || out_ready; handshake fires when in_valid && in_ready.
REQ-021 EMPTY + fire -> FULL, word loaded; latency exactly one cycle from accepted input to out_valid.
REQ-022 FULL + out_ready && !in_valid -> EMPTY; FULL + out_ready && in_valid -> stay FULL, new word loaded same edge (no bubble).
REQ-023 FULL + !out_ready: instr, err held stable; in_ready=0; inputs ignored.
REQ-024 instr_count increments on each output handshake; wraps 16'hFFFF -> 0.
REQ-025 Unused fields for a format (e.g. rs2 for I, func3 for U/J) ignored.

Reset
REQ-026 On rst low, immediately: state EMPTY, out_valid=0, instr=0, err=0, instr_count=0; in_ready=1 after rst deasserts.
REQ-027 Reset while FULL discards pending word; no handshake counted.

Configuration
REQ-028 Macro RISCV_ENC_RANGE_CHECK_EN defined: err=1 when imm does not fit format -- I/S outside [-2048,2047]; B outside [-4096,4094] or odd; J outside [-1048576,1048574] or odd; U with imm[11:0]!=0; word still emitted with truncated fields.
REQ-029 Macro undefined: no range check; err=1 only for unsupported opcode; imm silently truncated per REQ-016/017.

Verification
REQ-030 add x3,x1,x2 (opcode 0110011, func3 0, func7 0, rd 3, rs1 1, rs2 2), out_ready=1 -> next cycle out_valid=1, instr=32'h002081B3, err=0.
REQ-031 addi x5,x0,-1 -> instr=32'hFFF00293; sw x2,8(x1) -> 32'h0020A423; beq x0,x0,-4 -> 32'hFE000EE3; all err=0.
REQ-032 addi x5,x0,imm=2048 -> instr=32'h80000293; err=1 with RISCV_ENC_RANGE_CHECK_EN, err=0 without.
REQ-033 out_ready=0 for 5 cycles while FULL, in_valid=1 -> in_ready=0, instr unchanged; raise out_ready with in_valid=1 -> back-to-back words, instr_count +1 per cycle.
REQ-034 opcode 1111111 -> instr=0, err=1; assert rst while FULL -> out_valid=0, instr_count=0 without waiting for clk.
